// File: rtl/metric_tracker.sv
// metric_tracker: keeps the best (metric, nonce) pair seen in a candidate stream. When the best
// strictly improves and the new metric reaches a threshold, it raises a single-entry report to the
// host. It also counts accepted candidates and flags a full 160-bit match.
//
// Optional feature macro: METRIC_TRACKER_DROPS_EN
//   defined   - drops_o counts pending reports overwritten before the host accepted them
//   undefined - no drop counter is built and drops_o is tied to 0
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous restart of all search state (highest priority)
//   threshold_i     minimum metric that is reported; values above 160 disable reports
//   in_valid_i      candidate present (no backpressure)
//   in_metric_i     candidate metric, legal range 0..160
//   in_nonce_i      candidate nonce
//   best_metric_o   best metric so far
//   best_nonce_o    nonce that produced best_metric_o
//   out_valid_o     report pending
//   out_ready_i     host accepts the report
//   out_metric_o    reported metric
//   out_nonce_o     reported nonce
//   hit_o           sticky full-match flag
//   count_o         accepted candidates, saturating
//   drops_o         reports overwritten before acceptance, saturating
module metric_tracker #(
  parameter int unsigned NONCE_W  = 64,
  parameter int unsigned METRIC_W = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [METRIC_W-1:0] threshold_i,
  input  logic                in_valid_i,
  input  logic [METRIC_W-1:0] in_metric_i,
  input  logic [NONCE_W-1:0]  in_nonce_i,
  output logic [METRIC_W-1:0] best_metric_o,
  output logic [NONCE_W-1:0]  best_nonce_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [METRIC_W-1:0] out_metric_o,
  output logic [NONCE_W-1:0]  out_nonce_o,
  output logic                hit_o,
  output logic [31:0]         count_o,
  output logic [15:0]         drops_o
);

  localparam logic [METRIC_W-1:0] FullMatch = METRIC_W'(160);
  localparam logic [31:0]         CountMax  = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    StIdle,
    StPend
  } state_e;

  state_e state_q, state_d;

  logic [METRIC_W-1:0] best_metric_q, best_metric_d;
  logic [NONCE_W-1:0]  best_nonce_q,  best_nonce_d;
  logic [METRIC_W-1:0] out_metric_q,  out_metric_d;
  logic [NONCE_W-1:0]  out_nonce_q,   out_nonce_d;
  logic                hit_q,         hit_d;
  logic [31:0]         count_q,       count_d;

  logic accept;      // candidate taken this cycle (valid and not cleared)
  logic update;      // candidate strictly beats the current best
  logic report;      // improvement that also reaches the threshold
  logic load_report;
  logic drop_inc;

  assign accept = in_valid_i && !clear_i;
  assign update = accept && (in_metric_i > best_metric_q);
  assign report = update && (in_metric_i >= threshold_i);

  // Report handshake FSM. clear_i discards a pending report even when the host is ready.
  always_comb begin
    state_d     = state_q;
    load_report = 1'b0;
    drop_inc    = 1'b0;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (report) begin
            load_report = 1'b1;
            state_d     = StPend;
          end
        end
        StPend: begin
          if (report) begin
            // Old report is either consumed this edge or lost to the better one.
            load_report = 1'b1;
            drop_inc    = !out_ready_i;
          end else if (out_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Search state next-state.
  always_comb begin
    best_metric_d = best_metric_q;
    best_nonce_d  = best_nonce_q;
    out_metric_d  = out_metric_q;
    out_nonce_d   = out_nonce_q;
    hit_d         = hit_q;
    count_d       = count_q;
    if (clear_i) begin
      best_metric_d = '0;
      best_nonce_d  = '0;
      out_metric_d  = '0;
      out_nonce_d   = '0;
      hit_d         = 1'b0;
      count_d       = '0;
    end else begin
      if (update) begin
        best_metric_d = in_metric_i;
        best_nonce_d  = in_nonce_i;
      end
      if (load_report) begin
        out_metric_d = in_metric_i;
        out_nonce_d  = in_nonce_i;
      end
      if (accept && (in_metric_i == FullMatch)) begin
        hit_d = 1'b1;
      end
      if (accept && (count_q != CountMax)) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      best_metric_q <= '0;
      best_nonce_q  <= '0;
      out_metric_q  <= '0;
      out_nonce_q   <= '0;
      hit_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      best_metric_q <= best_metric_d;
      best_nonce_q  <= best_nonce_d;
      out_metric_q  <= out_metric_d;
      out_nonce_q   <= out_nonce_d;
      hit_q         <= hit_d;
      count_q       <= count_d;
    end
  end

`ifdef METRIC_TRACKER_DROPS_EN
  logic [15:0] drops_q, drops_d;

  always_comb begin
    drops_d = drops_q;
    if (clear_i) begin
      drops_d = '0;
    end else if (drop_inc && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drops_q <= '0;
    end else begin
      drops_q <= drops_d;
    end
  end

  assign drops_o = drops_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
  assign drops_o         = '0;
`endif

  // Valid decodes straight from the state flop, so async reset drops it at once.
  assign out_valid_o   = (state_q == StPend);
  assign best_metric_o = best_metric_q;
  assign best_nonce_o  = best_nonce_q;
  assign out_metric_o  = out_metric_q;
  assign out_nonce_o   = out_nonce_q;
  assign hit_o         = hit_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_metric_tracker.sv
// Table-driven bench for metric_tracker: each record drives one cycle of inputs and lists the
// outputs expected after the edge, plus whether a report transfer was expected on that edge.
module tb_metric_tracker;

`ifdef METRIC_TRACKER_DROPS_EN
  localparam bit DropsEn = 1'b1;
`else
  localparam bit DropsEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [8:0]  threshold;
  logic        in_valid;
  logic [8:0]  in_metric;
  logic [63:0] in_nonce;
  logic [8:0]  best_metric;
  logic [63:0] best_nonce;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_metric;
  logic [63:0] out_nonce;
  logic        hit;
  logic [31:0] count;
  logic [15:0] drops;

  metric_tracker #(
    .NONCE_W (64),
    .METRIC_W(9)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .threshold_i  (threshold),
    .in_valid_i   (in_valid),
    .in_metric_i  (in_metric),
    .in_nonce_i   (in_nonce),
    .best_metric_o(best_metric),
    .best_nonce_o (best_nonce),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_metric_o (out_metric),
    .out_nonce_o  (out_nonce),
    .hit_o        (hit),
    .count_o      (count),
    .drops_o      (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int thr;
    bit v;
    int m;
    int n;
    bit rdy;
    bit clr;
    int bm;
    int bn;
    bit val;
    int om;
    int on;
    int cnt;
    bit hit;
    int drp;
    bit xf;
    int xm;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs [NumVec];

  int passed;
  int total;
  bit xfer_seen;
  int xfer_m;

  function automatic vec_t mk(int thr, bit v, int m, int n, bit rdy, bit clr, int bm, int bn,
                              bit val, int om, int on, int cnt, bit h, int drp, bit xf, int xm);
    vec_t r;
    r.thr = thr; r.v = v; r.m = m; r.n = n; r.rdy = rdy; r.clr = clr;
    r.bm = bm; r.bn = bn; r.val = val; r.om = om; r.on = on; r.cnt = cnt;
    r.hit = h; r.drp = DropsEn ? drp : 0; r.xf = xf; r.xm = xm;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Drive one cycle of inputs, note whether a transfer happens on the coming edge, then step.
  task automatic cyc(input int thr, input bit v, input int m, input int n, input bit rdy,
                     input bit clr);
    threshold = 9'(thr);
    in_valid  = v;
    in_metric = 9'(m);
    in_nonce  = 64'(n);
    out_ready = rdy;
    clear     = clr;
    xfer_seen = out_valid && rdy && !clr;
    xfer_m    = int'(out_metric);
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    threshold = '0;
    in_valid  = 1'b0;
    in_metric = '0;
    in_nonce  = '0;
    out_ready = 1'b0;

    //           thr  v  m    n   rdy clr bm   bn  val om   on  cnt hit drp xf xm
    vecs[0]  = mk(10, 1, 5,   1,  1,  0,  5,   1,  0,  0,   0,  1,  0,  0,  0, 0);
    vecs[1]  = mk(10, 1, 12,  2,  1,  0,  12,  2,  1,  12,  2,  2,  0,  0,  0, 0);
    vecs[2]  = mk(10, 1, 12,  3,  1,  0,  12,  2,  0,  12,  2,  3,  0,  0,  1, 12);
    vecs[3]  = mk(10, 1, 11,  4,  1,  0,  12,  2,  0,  12,  2,  4,  0,  0,  0, 0);
    vecs[4]  = mk(0,  0, 0,   0,  0,  1,  0,   0,  0,  0,   0,  0,  0,  0,  0, 0);
    vecs[5]  = mk(0,  1, 3,   10, 0,  0,  3,   10, 1,  3,   10, 1,  0,  0,  0, 0);
    vecs[6]  = mk(0,  1, 7,   11, 0,  0,  7,   11, 1,  7,   11, 2,  0,  1,  0, 0);
    vecs[7]  = mk(0,  1, 9,   12, 0,  0,  9,   12, 1,  9,   12, 3,  0,  2,  0, 0);
    vecs[8]  = mk(0,  0, 0,   0,  1,  0,  9,   12, 0,  9,   12, 3,  0,  2,  1, 9);
    vecs[9]  = mk(0,  1, 20,  13, 0,  0,  20,  13, 1,  20,  13, 4,  0,  2,  0, 0);
    vecs[10] = mk(0,  1, 25,  14, 1,  0,  25,  14, 1,  25,  14, 5,  0,  2,  1, 20);
    vecs[11] = mk(0,  0, 0,   0,  1,  0,  25,  14, 0,  25,  14, 5,  0,  2,  1, 25);
    vecs[12] = mk(0,  1, 160, 15, 0,  0,  160, 15, 1,  160, 15, 6,  1,  2,  0, 0);
    vecs[13] = mk(0,  1, 160, 16, 0,  0,  160, 15, 1,  160, 15, 7,  1,  2,  0, 0);
    vecs[14] = mk(0,  0, 0,   0,  1,  0,  160, 15, 0,  160, 15, 7,  1,  2,  1, 160);
    vecs[15] = mk(0,  0, 0,   0,  0,  1,  0,   0,  0,  0,   0,  0,  0,  0,  0, 0);
    vecs[16] = mk(0,  1, 30,  17, 0,  0,  30,  17, 1,  30,  17, 1,  0,  0,  0, 0);
    vecs[17] = mk(0,  1, 50,  18, 1,  1,  0,   0,  0,  0,   0,  0,  0,  0,  0, 0);
    vecs[18] = mk(161, 1, 100, 19, 0, 0,  100, 19, 0,  0,   0,  1,  0,  0,  0, 0);
    vecs[19] = mk(161, 1, 160, 20, 0, 0,  160, 20, 0,  0,   0,  2,  1,  0,  0, 0);
    vecs[20] = mk(50, 0, 0,   0,  0,  1,  0,   0,  0,  0,   0,  0,  0,  0,  0, 0);
    vecs[21] = mk(50, 1, 50,  21, 0,  0,  50,  21, 1,  50,  21, 1,  0,  0,  0, 0);
    vecs[22] = mk(50, 1, 160, 22, 0,  0,  160, 22, 1,  160, 22, 2,  1,  1,  0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset best_m", 64'(best_metric), 64'd0);
    chk("reset best_n", best_nonce, 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset hit", 64'(hit), 64'd0);
    chk("reset drops", 64'(drops), 64'd0);
    chk("reset out_m", 64'(out_metric), 64'd0);

    for (int i = 0; i < NumVec; i++) begin
      cyc(vecs[i].thr, vecs[i].v, vecs[i].m, vecs[i].n, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("v%0d best_m", i), 64'(best_metric), 64'(vecs[i].bm));
      chk($sformatf("v%0d best_n", i), best_nonce, 64'(vecs[i].bn));
      chk($sformatf("v%0d valid", i), 64'(out_valid), 64'(vecs[i].val));
      chk($sformatf("v%0d out_m", i), 64'(out_metric), 64'(vecs[i].om));
      chk($sformatf("v%0d out_n", i), out_nonce, 64'(vecs[i].on));
      chk($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].cnt));
      chk($sformatf("v%0d hit", i), 64'(hit), 64'(vecs[i].hit));
      chk($sformatf("v%0d drops", i), 64'(drops), 64'(vecs[i].drp));
      chk($sformatf("v%0d xfer", i), 64'(xfer_seen), 64'(vecs[i].xf));
      if (vecs[i].xf) begin
        chk($sformatf("v%0d xfer_m", i), 64'(xfer_m), 64'(vecs[i].xm));
      end
    end

    // Count saturation: preload the counter just below its ceiling.
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    cyc(50, 1, 0, 30, 0, 0);
    chk("sat count 1", 64'(count), 64'hFFFF_FFFF);
    cyc(50, 1, 0, 31, 0, 0);
    chk("sat count 2", 64'(count), 64'hFFFF_FFFF);
    chk("sat valid held", 64'(out_valid), 64'd1);

    // Async reset mid-report, sampled well before the next clock edge.
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", 64'(out_valid), 64'd0);
    chk("arst best_m", 64'(best_metric), 64'd0);
    chk("arst best_n", best_nonce, 64'd0);
    chk("arst out_m", 64'(out_metric), 64'd0);
    chk("arst out_n", out_nonce, 64'd0);
    chk("arst count", 64'(count), 64'd0);
    chk("arst hit", 64'(hit), 64'd0);
    chk("arst drops", 64'(drops), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
